irq_router: RTL and testbench
=============================

# irq_router

Parametrised CSR-mapped interrupt controller. It accepts up to 16 asynchronous board interrupt sources and for each one provides:
- a 2-FF synchroniser;
- a selectable polarity;
- edge or level trigger mode;
- a sticky write-1-to-clear pending bit;
- an enable mask.

It drives one registered, active-high `irq` output, which the top level routes to the SoC interrupt/RCW_SRC2 pin. It sits on the shared 5-bit-address/8-bit-data CSR bus alongside the other peripherals.

## Interface
Parameters:
- `BASE_ADDR`, 5'h1c: CSR address of bank 0. Bank b occupies `BASE_ADDR+4b .. +4b+3`.
- `NUM_INTS`, 7: number of sources, 1..16. NUM_BANKS = 1 if NUM_INTS ≤ 8, else 2.
- `DFL_IE`, all 0: reset value of the enable mask.
- `DFL_MODE`, all 0: reset trigger mode; 1 = edge, 0 = level.
- `DFL_POL`, all 0: reset polarity; 1 = active-high, 0 = active-low.

Ports:
- Clock and reset:
  - `clk`, in, 1: single clock; everything is synchronous to its rising edge.
  - `rst_n`, in, 1: synchronous, active-low reset.
- CSR bus:
  - `csr_a`, in, 5: CSR address.
  - `csr_di`, in, 8: write data.
  - `csr_we`, in, 1: write strobe, one cycle per write.
  - `csr_do`, out, 8: read data. Combinational decode of registered state; 8'h00 when `csr_a` is outside this block's range.
- Sources and output:
  - `int`, in, NUM_INTS: raw, asynchronous interrupt sources.
  - `irq`, out, 1: registered; equals |(IP & IE).

## Operation
Register map, per bank b (bits beyond NUM_INTS are read-only 0 and writes to them are ignored):
- +0 IE: interrupt enable, R/W.
- +1 IP: pending. Reads return status; writing 1 clears a bit, writing 0 has no effect.
- +2 MODE: trigger mode, R/W.
- +3 POL: polarity, R/W.

Per-source pipeline:
- Synchronisation: s1 <= int; s2 <= s1.
- Active level: act = POL ? s2 : ~s2.
- Delayed copy: act_d <= act.
- IP set condition:
  - Level mode: set every cycle that act = 1.
  - Edge mode: set on act & ~act_d, and only when armed.
- Set and W1C on the same bit in the same cycle: set wins, IP stays 1.
- In level mode, W1C while the source is still active re-sets IP on the next evaluation. Software must clear the cause first.
- A write to MODE or POL of a bank suppresses edge detection for that bank in the following cycle, so a polarity flip cannot create a false edge.
- IE gates only `irq`; IP latches regardless of IE.

Arming:
- A 2-bit counter starts at 0 on reset and saturates at 3.
- Edge detection is armed only when the counter = 3, i.e. the sync pipe has been refilled after reset.
- Consequence: a source already active when reset releases raises no edge interrupt. Level sources do raise one.

Reset values (while `rst_n` = 0 at a clock edge):
- IE = DFL_IE, MODE = DFL_MODE, POL = DFL_POL.
- IP = 0, s1 = s2 = act_d = 0, arm counter = 0, `irq` = 0.

Reset asserted mid-operation discards pending bits; no interrupt is generated on reset release except from level-mode sources that are active.

## Timing
- `int` changes before edge k: s1 at k, s2 at k+1, IP visible in a CSR read after k+2, `irq` high after k+3.
- The 4-cycle input-to-irq latency is a requirement.
- Minimum pulse for a guaranteed edge capture: 2 clk periods. Shorter pulses may be lost.
- CSR write takes effect at the clock edge where `csr_we` = 1.
- W1C on IP: IP low after that edge; `irq` low one cycle later, if no other enabled pending bit remains.
- IE write: `irq` reflects the new mask one cycle after the write edge.
- `csr_do` is valid in the same cycle as `csr_a`; no wait states.

## Structure
- Shared package holds:
  - register offset constants: IE = 0, IP = 1, MODE = 2, POL = 3;
  - the bank stride, 4;
  - the MODE encoding constants EDGE = 1, LEVEL = 0.
- One sub-module, `irq_src_cell`: a single source's sync/act/edge/IP logic, instantiated NUM_INTS times via a generate loop.
- The top of `irq_router` holds the CSR decode, the IE/MODE/POL registers, the arm counter and the `irq` reduction register.

## Test plan
- Reset with NUM_INTS = 7, `int` = 7'h7F, DFL_POL = 0: after release, IP = 0 and `irq` = 0 for all cycles; a read of BASE_ADDR+1 returns 8'h00.
- Edge mode, POL = 0, IE[0] = 1: pull `int[0]` low for 2 cycles → IP[0] = 1 and `irq` = 1 at k+3. Write 8'h01 to IP → IP = 0 and `irq` = 0 one cycle later. The input stays low, so no re-trigger.
- Level mode, POL = 1, `int[2]` held high: W1C of 8'h04 → IP[2] reads 1 again two cycles later. Drop the input, then W1C → IP stays 0.
- Same-cycle collision: the edge-set cycle of `int[1]` coincides with a W1C of 8'h02 → IP[1] = 1 afterwards.
- Flip POL on a steady edge-mode source → no IP set. NUM_INTS = 12: an edge on `int[10]` sets bank-1 IP bit 2 (BASE_ADDR+5 = 8'h04); a read of bank-1 bits 7:4 returns 0.
- Assert `rst_n` = 0 for one cycle while IP = 8'h13 and `irq` = 1 → the next cycle shows IP = 0, `irq` = 0 and IE = DFL_IE.

Source files
------------

// File: rtl/irq_router_pkg.sv
// Shared constants for the irq_router CSR map and the per-source trigger encoding.
package irq_router_pkg;

  typedef enum logic [1:0] {
    REG_IE   = 2'd0,
    REG_IP   = 2'd1,
    REG_MODE = 2'd2,
    REG_POL  = 2'd3
  } reg_off_e;

  localparam int   BANK_STRIDE = 4;
  localparam logic MODE_EDGE   = 1'b1;
  localparam logic MODE_LEVEL  = 1'b0;

  // One bit per implemented source, packed into the 16-bit register view.
  function automatic logic [15:0] valid_mask(input int n);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: 2-FF synchroniser, polarity, edge/level detect and sticky W1C pending bit.
module irq_src_cell
  import irq_router_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic int_in,
  input  logic pol,
  input  logic mode,
  input  logic edge_en,
  input  logic level_en,
  input  logic ip_clr,
  output logic ip
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic act_d_q, act_d_d;
  logic ip_q, ip_d;
  logic act;
  logic set;

  always_comb begin
    s1_d    = int_in;
    s2_d    = s1_q;
    act     = pol ? s2_q : ~s2_q;
    act_d_d = act;
    set     = (mode == MODE_EDGE) ? (edge_en & act & ~act_d_q) : (level_en & act);
    // A set in the same cycle as a clear keeps the bit pending.
    ip_d    = set | (ip_q & ~ip_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      act_d_q <= 1'b0;
      ip_q    <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      act_d_q <= act_d_d;
      ip_q    <= ip_d;
    end
  end

  assign ip = ip_q;

endmodule

// File: rtl/irq_router.sv
// CSR-mapped interrupt controller: CSR decode, IE/MODE/POL banks, arm counter and registered irq.
module irq_router
  import irq_router_pkg::*;
#(
  parameter logic [4:0]  BASE_ADDR = 5'h1c,
  parameter int          NUM_INTS  = 7,
  parameter logic [15:0] DFL_IE    = '0,
  parameter logic [15:0] DFL_MODE  = '0,
  parameter logic [15:0] DFL_POL   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_INTS-1:0] int_in,
  output logic                irq
);

  localparam int          NUM_BANKS = (NUM_INTS <= 8) ? 1 : 2;
  localparam logic [15:0] VALID     = valid_mask(NUM_INTS);

  logic [15:0] ie_q, ie_d;
  logic [15:0] mode_q, mode_d;
  logic [15:0] pol_q, pol_d;
  logic [NUM_BANKS-1:0] supp_q, supp_d;
  logic [1:0]  arm_q, arm_d;
  logic        irq_q, irq_d;

  logic [4:0]  off;
  logic [2:0]  bank_idx;
  reg_off_e    reg_sel;
  logic        hit;
  logic [15:0] wr_data, wr_mask, rd_word;
  logic [NUM_INTS-1:0] ip_clr;
  logic [15:0] ip_vec;
  logic        edge_armed;

  // Bank/offset decode; address arithmetic wraps within the 5-bit CSR space.
  always_comb begin
    off      = csr_a - BASE_ADDR;
    bank_idx = off[4:2];
    reg_sel  = reg_off_e'(off[1:0]);
    hit      = (bank_idx < 3'(NUM_BANKS));
    wr_data  = off[2] ? {csr_di, 8'h00} : {8'h00, csr_di};
    wr_mask  = (off[2] ? 16'hFF00 : 16'h00FF) & VALID;
  end

  always_comb begin
    ie_d   = ie_q;
    mode_d = mode_q;
    pol_d  = pol_q;
    supp_d = '0;
    ip_clr = '0;
    arm_d  = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    irq_d  = |(ip_vec & ie_q);
    if (csr_we && hit) begin
      case (reg_sel)
        REG_IE:   ie_d   = (ie_q & ~wr_mask) | (wr_data & wr_mask);
        REG_IP:   ip_clr = wr_data[NUM_INTS-1:0] & wr_mask[NUM_INTS-1:0];
        REG_MODE: mode_d = (mode_q & ~wr_mask) | (wr_data & wr_mask);
        REG_POL:  pol_d  = (pol_q & ~wr_mask) | (wr_data & wr_mask);
        default:  ie_d   = ie_q;
      endcase
      // A trigger reconfiguration blanks edge detection of that bank for one cycle.
      if (reg_sel == REG_MODE || reg_sel == REG_POL) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          supp_d[b] = (off[2] == 1'(b));
        end
      end
    end
  end

  always_comb begin
    case (reg_sel)
      REG_IE:   rd_word = ie_q;
      REG_IP:   rd_word = ip_vec;
      REG_MODE: rd_word = mode_q;
      default:  rd_word = pol_q;
    endcase
    csr_do = hit ? (off[2] ? rd_word[15:8] : rd_word[7:0]) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie_q   <= DFL_IE & VALID;
      mode_q <= DFL_MODE & VALID;
      pol_q  <= DFL_POL & VALID;
      supp_q <= '0;
      arm_q  <= 2'd0;
      irq_q  <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      mode_q <= mode_d;
      pol_q  <= pol_d;
      supp_q <= supp_d;
      arm_q  <= arm_d;
      irq_q  <= irq_d;
    end
  end

  // Level sets wait for the sync pipe to hold real samples; edges also need a valid act_d.
  assign edge_armed = (arm_q == 2'd3);

  for (genvar i = 0; i < 16; i++) begin : g_src
    if (i < NUM_INTS) begin : g_cell
      irq_src_cell u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .int_in   (int_in[i]),
        .pol      (pol_q[i]),
        .mode     (mode_q[i]),
        .edge_en  (edge_armed & ~supp_q[i / 8]),
        .level_en (arm_q[1]),
        .ip_clr   (ip_clr[i]),
        .ip       (ip_vec[i])
      );
    end else begin : g_pad
      assign ip_vec[i] = 1'b0;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_irq_router.sv
// Self-checking bench for irq_router: register table plus hand-written trigger/reset sequences.
module tb_irq_router;

   // Clock, shared CSR bus, and two router instances (7 and 12 sources).
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  csrA;
   logic [7:0]  csrDi;
   logic        csrWe;
   logic        sel12;
   logic        we7, we12;
   logic [6:0]  int7;
   logic [11:0] int12;
   logic [7:0]  do7, do12;
   logic        irq7, irq12;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      string      name;
      logic [4:0] a;
      logic [7:0] di;
      logic       we;
      logic [7:0] expDo;
      logic       expIrq;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   assign we7  = csrWe & ~sel12;
   assign we12 = csrWe & sel12;

   irq_router #(.NUM_INTS(7)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .csr_a  (csrA),
      .csr_di (csrDi),
      .csr_we (we7),
      .csr_do (do7),
      .int_in (int7),
      .irq    (irq7)
   );

   irq_router #(.NUM_INTS(12)) dut12 (
      .clk    (clk),
      .rst_n  (rst_n),
      .csr_a  (csrA),
      .csr_di (csrDi),
      .csr_we (we12),
      .csr_do (do12),
      .int_in (int12),
      .irq    (irq12)
   );

   // Compare one value and report any difference.
   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", name, actual, expected);
      end
   endtask

   // Advance whole cycles; returns on the falling edge so inputs change away from posedge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // One-cycle CSR write strobe.
   task automatic csrWrite(input logic [4:0] a, input logic [7:0] d);
      csrA  = a;
      csrDi = d;
      csrWe = 1'b1;
      tick();
      csrWe = 1'b0;
   endtask

   // Combinational read of the selected instance, then compare.
   task automatic checkRead(input string name, input logic [4:0] a, input logic [7:0] expected);
      csrA = a;
      #1;
      checkOutput(name, sel12 ? do12 : do7, expected);
   endtask

   task automatic checkIrq(input string name, input logic expected);
      checkOutput(name, {7'b0, sel12 ? irq12 : irq7}, {7'b0, expected});
   endtask

   // Table vector: optional write, then read back at the same address and check irq.
   task automatic applyStimulus(input vec_t v);
      if (v.we) csrWrite(v.a, v.di);
      checkRead(v.name, v.a, v.expDo);
      checkIrq({v.name, "_irq"}, v.expIrq);
   endtask

   initial begin
      vecs[0] = '{"ie_all",      5'h1c, 8'hFF, 1'b1, 8'h7F, 1'b0};
      vecs[1] = '{"ie_05",       5'h1c, 8'h05, 1'b1, 8'h05, 1'b0};
      vecs[2] = '{"mode_5a",     5'h1e, 8'h5A, 1'b1, 8'h5A, 1'b0};
      vecs[3] = '{"mode_00",     5'h1e, 8'h00, 1'b1, 8'h00, 1'b0};
      vecs[4] = '{"pol_bit7",    5'h1f, 8'h80, 1'b1, 8'h00, 1'b0};
      vecs[5] = '{"oor_write",   5'h00, 8'hFF, 1'b1, 8'h00, 1'b0};
      vecs[6] = '{"ie_kept",     5'h1c, 8'h00, 1'b0, 8'h05, 1'b0};
      vecs[7] = '{"ip_idle",     5'h1d, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[8] = '{"oor_below",   5'h1b, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[9] = '{"ie_clear",    5'h1c, 8'h00, 1'b1, 8'h00, 1'b0};

      rst_n = 1'b0;
      csrA  = 5'h00;
      csrDi = 8'h00;
      csrWe = 1'b0;
      sel12 = 1'b0;
      int7  = 7'h7F;
      int12 = 12'hFFF;

      // Reset with all inputs idle-high under active-low polarity: nothing may pend.
      tick(2);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         checkRead("rst_ip", 5'h1d, 8'h00);
         checkIrq("rst_irq", 1'b0);
         tick();
      end
      checkRead("rst_ie", 5'h1c, 8'h00);

      for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

      // Edge mode, active-low source 0.
      csrWrite(5'h1e, 8'h01);
      csrWrite(5'h1c, 8'h01);
      tick(3);
      int7[0] = 1'b0;
      tick(3);
      checkRead("edge_ip_k2", 5'h1d, 8'h01);
      checkIrq("edge_irq_k2", 1'b0);
      tick();
      checkIrq("edge_irq_k3", 1'b1);
      csrWrite(5'h1d, 8'h01);
      checkRead("edge_w1c_ip", 5'h1d, 8'h00);
      checkIrq("edge_w1c_irq_hold", 1'b1);
      tick();
      checkIrq("edge_w1c_irq_low", 1'b0);
      tick(3);
      checkRead("edge_no_retrig", 5'h1d, 8'h00);

      // Level mode, active-high source 2 held active.
      csrWrite(5'h1f, 8'h04);
      tick(3);
      checkRead("lvl_set", 5'h1d, 8'h04);
      csrWrite(5'h1d, 8'h04);
      checkRead("lvl_w1c_active", 5'h1d, 8'h04);
      tick(2);
      checkRead("lvl_reset_again", 5'h1d, 8'h04);
      int7[2] = 1'b0;
      tick(3);
      csrWrite(5'h1d, 8'h04);
      checkRead("lvl_cleared", 5'h1d, 8'h00);
      tick(2);
      checkRead("lvl_stays_clear", 5'h1d, 8'h00);

      // Edge-set cycle of source 1 collides with its W1C.
      csrWrite(5'h1e, 8'h03);
      tick(3);
      int7[1] = 1'b0;
      tick(2);
      csrWrite(5'h1d, 8'h02);
      checkRead("collide_set_wins", 5'h1d, 8'h02);
      tick();
      checkRead("collide_sticky", 5'h1d, 8'h02);
      csrWrite(5'h1d, 8'h02);
      checkRead("collide_clear", 5'h1d, 8'h00);

      // Polarity flips on a steady edge-mode source must not fake an edge.
      csrWrite(5'h1f, 8'h06);
      tick(3);
      checkRead("polflip_deassert", 5'h1d, 8'h00);
      csrWrite(5'h1f, 8'h04);
      tick(4);
      checkRead("polflip_assert", 5'h1d, 8'h00);

      // Build IP = 8'h13 with irq high, then pulse reset for one cycle.
      int7[4] = 1'b0;
      csrWrite(5'h1e, 8'h00);
      tick(4);
      csrWrite(5'h1c, 8'h13);
      tick(2);
      checkRead("pre_rst_ip", 5'h1d, 8'h13);
      checkIrq("pre_rst_irq", 1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkRead("midrst_ip", 5'h1d, 8'h00);
      checkIrq("midrst_irq", 1'b0);
      checkRead("midrst_ie", 5'h1c, 8'h00);
      checkRead("midrst_mode", 5'h1e, 8'h00);
      checkRead("midrst_pol", 5'h1f, 8'h00);
      tick(5);
      checkRead("post_rst_level", 5'h1d, 8'h17);
      checkIrq("post_rst_irq", 1'b0);

      // Twelve sources: bank 1 sits at BASE_ADDR+4, wrapping to 5'h00.
      sel12 = 1'b1;
      csrWrite(5'h02, 8'h04);
      csrWrite(5'h00, 8'hFF);
      checkRead("b1_ie_mask", 5'h00, 8'h0F);
      tick(2);
      int12[10] = 1'b0;
      tick(2);
      checkIrq("b1_irq_k1", 1'b0);
      tick();
      checkRead("b1_ip", 5'h01, 8'h04);
      checkRead("b0_ip", 5'h1d, 8'h00);
      checkIrq("b1_irq_k2", 1'b0);
      tick();
      checkIrq("b1_irq_k3", 1'b1);
      checkRead("b1_pol", 5'h03, 8'h00);
      checkRead("b2_oor", 5'h04, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
